// File: rtl/ehl_gpio_arb.sv
// Round-robin arbiter sharing one GPIO set/clear/invert/write port among NREQ requesters, with optional lock and idle timeout.
// Latency 1 (transfer in T -> strobes in T+1); one-hot combinational req_ready, no back-pressure from the register port.
module ehl_gpio_arb #(
    parameter int WIDTH    = 32,
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int LOCK_TMO = 16,
    parameter int TMOW     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [WIDTH*NREQ-1:0] req_data,
    output logic                  write_reg,
    output logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      set_reg,
    output logic [WIDTH-1:0]      clr_reg,
    output logic [WIDTH-1:0]      inv_reg,
    output logic [IDW-1:0]        grant_id,
    output logic                  cmd_vld,
    output logic                  locked,
    output logic                  lock_err
);

    typedef enum logic {ARB, LOCKED} state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  owner;
    logic [TMOW-1:0] tmo_cnt;

    logic            arb_hit;
    logic [IDW-1:0]  arb_idx;
    logic            xfer;
    logic [IDW-1:0]  sel_id;
    logic [1:0]      sel_op;
    logic [WIDTH-1:0] sel_data;
    logic            sel_lock;
    logic            tmo_hit;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
    endfunction

    // Two passes give the rotating priority: ptr..NREQ-1 first, then 0..ptr-1.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_hit && req_valid[i] && i >= int'(ptr)) begin
                arb_hit = 1'b1;
                arb_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!arb_hit && req_valid[i]) begin
                arb_hit = 1'b1;
                arb_idx = IDW'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                if (state == ARB)
                    req_ready[i] = arb_hit && (arb_idx == IDW'(i));
                else
                    req_ready[i] = req_valid[i] && (owner == IDW'(i));
            end
        end
    end

    // req_ready is one-hot, so the mux just picks the accepted requester.
    always_comb begin
        sel_id   = '0;
        sel_op   = OP_WRITE;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_id   = IDW'(i);
                sel_op   = req_op[2*i +: 2];
                sel_data = req_data[WIDTH*i +: WIDTH];
                sel_lock = req_lock[i];
            end
        end
    end

    assign xfer    = |(req_valid & req_ready);
    assign tmo_hit = (LOCK_TMO != 0) && (tmo_cnt == TMOW'(LOCK_TMO - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB;
            ptr       <= '0;
            owner     <= '0;
            tmo_cnt   <= '0;
            write_reg <= 1'b0;
            data_in   <= '0;
            set_reg   <= '0;
            clr_reg   <= '0;
            inv_reg   <= '0;
            grant_id  <= '0;
            cmd_vld   <= 1'b0;
            locked    <= 1'b0;
            lock_err  <= 1'b0;
        end else begin
            cmd_vld   <= xfer;
            grant_id  <= xfer ? sel_id : '0;
            write_reg <= xfer && (sel_op == OP_WRITE);
            data_in   <= (xfer && sel_op == OP_WRITE) ? sel_data : '0;
            set_reg   <= (xfer && sel_op == OP_SET)   ? sel_data : '0;
            clr_reg   <= (xfer && sel_op == OP_CLEAR) ? sel_data : '0;
            inv_reg   <= (xfer && sel_op == OP_INV)   ? sel_data : '0;
            lock_err  <= 1'b0;

            case (state)
                ARB: begin
                    if (xfer) begin
                        ptr <= next_id(sel_id);
                        if (sel_lock) begin
                            state   <= LOCKED;
                            owner   <= sel_id;
                            tmo_cnt <= '0;
                            locked  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        tmo_cnt <= '0;
                        if (!sel_lock) begin
                            state  <= ARB;
                            ptr    <= next_id(owner);
                            locked <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state    <= ARB;
                        ptr      <= next_id(owner);
                        tmo_cnt  <= '0;
                        locked   <= 1'b0;
                        lock_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMOW'(1);
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_ehl_gpio_arb.sv
// Directed bench for ehl_gpio_arb: stimulus pushes expected commands, a monitor pops them when cmd_vld is seen.
// A second instance with the timeout disabled checks that a held lock never times out.
module tb_ehl_gpio_arb;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] data;
        logic [1:0]  id;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [7:0]   req_op = '0;
    logic [3:0]   req_lock = '0;
    logic [31:0]  dat [4];
    logic [127:0] req_data;
    logic         write_reg;
    logic [31:0]  data_in, set_reg, clr_reg, inv_reg;
    logic [1:0]   grant_id;
    logic         cmd_vld, locked, lock_err;

    logic [3:0]   v0 = '0;
    logic [3:0]   lk0 = '0;
    logic [3:0]   rdy0;
    logic         wr0, vld0, locked0, err0;
    logic [31:0]  din0, set0, clr0, inv0;
    logic [1:0]   gid0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errs = 0;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    ehl_gpio_arb #(.WIDTH(32), .NREQ(4), .IDW(2), .LOCK_TMO(4), .TMOW(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_lock(req_lock), .req_data(req_data),
        .write_reg(write_reg), .data_in(data_in), .set_reg(set_reg), .clr_reg(clr_reg),
        .inv_reg(inv_reg), .grant_id(grant_id), .cmd_vld(cmd_vld), .locked(locked),
        .lock_err(lock_err)
    );

    ehl_gpio_arb #(.WIDTH(32), .NREQ(4), .IDW(2), .LOCK_TMO(0), .TMOW(8)) dut_notmo (
        .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0),
        .req_op(8'h00), .req_lock(lk0), .req_data(128'h0),
        .write_reg(wr0), .data_in(din0), .set_reg(set0), .clr_reg(clr0),
        .inv_reg(inv0), .grant_id(gid0), .cmd_vld(vld0), .locked(locked0),
        .lock_err(err0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    // One cycle: drive after the edge, check state outputs and ready mid-cycle, queue accepted commands.
    task automatic step(input logic rst, input logic [3:0] v, input logic [7:0] op, input logic [3:0] lk,
                        input logic [3:0] erdy, input logic elocked, input logic eerr);
        @(posedge clk);
        #1;
        reset = rst;
        req_valid = v;
        req_op = op;
        req_lock = lk;
        #3;
        chk("req_ready", 64'(req_ready), 64'(erdy));
        chk("locked", 64'(locked), 64'(elocked));
        chk("lock_err", 64'(lock_err), 64'(eerr));
        for (int i = 0; i < 4; i++) begin
            if (v[i] && erdy[i])
                exp_q.push_back('{op: op[2*i +: 2], data: dat[i], id: 2'(i)});
        end
    endtask

    task automatic idle();
        step(1'b0, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        #2;
        if (cmd_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 64'(grant_id), 64'h0);
                n_errs++;
                $display("FAIL unexpected_cmd: cmd_vld=1 with nothing expected at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("grant_id", 64'(grant_id), 64'(e.id));
                chk("write_reg", 64'(write_reg), 64'(e.op == 2'b00));
                chk("data_in", 64'(data_in), 64'(e.op == 2'b00 ? e.data : 32'h0));
                chk("set_reg", 64'(set_reg), 64'(e.op == 2'b01 ? e.data : 32'h0));
                chk("clr_reg", 64'(clr_reg), 64'(e.op == 2'b10 ? e.data : 32'h0));
                chk("inv_reg", 64'(inv_reg), 64'(e.op == 2'b11 ? e.data : 32'h0));
            end
        end else begin
            chk("cmd_vld", 64'(cmd_vld), 64'h0);
            chk("idle_outputs", {write_reg, data_in | set_reg | clr_reg | inv_reg, grant_id}, 64'h0);
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) dat[i] = '0;

        step(1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // single write from req0, then silence
        dat[0] = 32'hA5A5_0000;
        step(1'b0, 4'b0001, 8'h00, 4'b0000, 4'b0001, 1'b0, 1'b0);
        idle();
        step(1'b1, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b0, 1'b0);

        // all four requesters streaming set ops
        for (int i = 0; i < 4; i++) dat[i] = 32'h1 << i;
        step(1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0010, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 8'h55, 4'b0000, 4'b1000, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 8'h55, 4'b0000, 4'b0010, 1'b0, 1'b0);
        idle();

        // req1 locks, idles 3 cycles, unlocks with clear 0xFF; req2 waits
        step(1'b0, 4'b0010, 8'h04, 4'b0010, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b0100, 8'h10, 4'b0000, 4'b0000, 1'b1, 1'b0);
        dat[1] = 32'h0000_00FF;
        step(1'b0, 4'b0110, 8'h18, 4'b0000, 4'b0010, 1'b1, 1'b0);
        step(1'b0, 4'b0100, 8'h10, 4'b0000, 4'b0100, 1'b0, 1'b0);
        idle();

        // req0 invert with lock then idle: timeout after 4 idle cycles
        dat[0] = 32'h1;
        step(1'b0, 4'b0001, 8'h03, 4'b0001, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 4'b1000, 8'h40, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b1000, 8'h40, 4'b0000, 4'b1000, 1'b0, 1'b1);
        idle();

        // reset while locked by req2; ptr restarts at 0; zero-data write from req0
        dat[2] = 32'h0000_FF00;
        step(1'b0, 4'b0100, 8'h10, 4'b0100, 4'b0100, 1'b0, 1'b0);
        step(1'b1, 4'b0101, 8'h10, 4'b0100, 4'b0000, 1'b1, 1'b0);
        dat[0] = 32'h0;
        step(1'b0, 4'b0101, 8'h10, 4'b0000, 4'b0001, 1'b0, 1'b0);
        idle();

        // req1 locks against req3, relocks (counter restarts), then times out
        step(1'b0, 4'b1010, 8'h44, 4'b0010, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 4'b1000, 8'h44, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b1010, 8'h44, 4'b0010, 4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 4'b1000, 8'h44, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b1000, 8'h44, 4'b0000, 4'b1000, 1'b0, 1'b1);
        idle();

        // timeout disabled: the lock holds indefinitely
        @(posedge clk);
        #1;
        v0 = 4'b0001;
        lk0 = 4'b0001;
        #3;
        chk("notmo_lock_rdy", 64'(rdy0), 64'h1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            v0 = 4'b0010;
            lk0 = 4'b0000;
            #3;
            chk("notmo_locked", 64'(locked0), 64'h1);
            chk("notmo_lock_err", 64'(err0), 64'h0);
            chk("notmo_rdy_held", 64'(rdy0), 64'h0);
        end
        @(posedge clk);
        #1;
        v0 = 4'b0011;
        #3;
        chk("notmo_unlock_rdy", 64'(rdy0), 64'h1);
        @(posedge clk);
        #1;
        v0 = 4'b0010;
        #3;
        chk("notmo_after_rdy", 64'(rdy0), 64'h2);
        chk("notmo_after_locked", 64'(locked0), 64'h0);
        chk("notmo_after_err", 64'(err0), 64'h0);
        @(posedge clk);
        #1;
        v0 = 4'b0000;

        idle();
        idle();
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
